// File: rtl/operand_scatter_pkg.sv
// Shared widths and collector state encoding for the 4-way operand scatter.
package operand_scatter_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } coll_state_e;

endpackage

// File: rtl/operand_scatter_4way_16bit.sv
// Gathers serial words into a 4-lane parallel group; out_valid one cycle after the closing word.
// A closed group waiting on a busy output slot parks in FULL and drops in_ready until it moves.
module operand_scatter_4way_16bit #(
  parameter int DATA_W = operand_scatter_pkg::DATA_W,
  parameter int LANES  = operand_scatter_pkg::LANES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out00,
  output logic [DATA_W-1:0] out01,
  output logic [DATA_W-1:0] out10,
  output logic [DATA_W-1:0] out11,
  output logic [2:0]        out_count,
  output logic              out_valid,
  input  logic              out_ready
);

  import operand_scatter_pkg::coll_state_e;
  import operand_scatter_pkg::ST_COLLECT;
  import operand_scatter_pkg::ST_FULL;

  coll_state_e       state_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] buf_q [LANES];
  logic [DATA_W-1:0] grp_d [LANES];
  logic [DATA_W-1:0] out_q [LANES];
  logic [2:0]        out_count_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              closing;
  logic              slot_free;

  // Unfilled lanes of buf_q are always zero, so the group only needs the new word dropped in.
  always_comb begin
    for (int i = 0; i < LANES; i++) grp_d[i] = buf_q[i];
    grp_d[cnt_q[1:0]] = in_data;
    closing   = in_last || (cnt_q == 3'd3);
    slot_free = !out_valid_q || out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= 3'd0;
      out_count_q <= 3'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        buf_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            if (closing && slot_free) begin
              for (int i = 0; i < LANES; i++) begin
                out_q[i] <= grp_d[i];
                buf_q[i] <= '0;
              end
              out_count_q <= cnt_q + 3'd1;
              out_valid_q <= 1'b1;
              cnt_q       <= 3'd0;
            end else begin
              for (int i = 0; i < LANES; i++) buf_q[i] <= grp_d[i];
              cnt_q <= cnt_q + 3'd1;
              if (closing) begin
                state_q    <= ST_FULL;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        ST_FULL: begin
          if (slot_free) begin
            for (int i = 0; i < LANES; i++) begin
              out_q[i] <= buf_q[i];
              buf_q[i] <= '0;
            end
            out_count_q <= cnt_q;
            out_valid_q <= 1'b1;
            cnt_q       <= 3'd0;
            state_q     <= ST_COLLECT;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out00     = out_q[0];
  assign out01     = out_q[1];
  assign out10     = out_q[2];
  assign out11     = out_q[3];
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_operand_scatter_4way_16bit.sv
// Directed stimulus with a queue scoreboard; the monitor pops one group per output handshake.
module tb_operand_scatter_4way_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out00, out01, out10, out11;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [15:0] l0;
    logic [15:0] l1;
    logic [15:0] l2;
    logic [15:0] l3;
    logic [2:0]  cnt;
  } grp_t;

  grp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  operand_scatter_4way_16bit #(.DATA_W(16), .LANES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out00     (out00),
    .out01     (out01),
    .out10     (out10),
    .out11     (out11),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected group.
  initial begin
    grp_t e;
    grp_t a;
    forever begin
      @(negedge clk);
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
        a = '{l0: out00, l1: out01, l2: out10, l3: out11, cnt: out_count};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_group: got %h with empty queue", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL group: got %h expected %h", a, e);
          end
        end
      end
    end
  end

  task automatic push(input logic [15:0] a, b, c, d, input logic [2:0] n);
    exp_q.push_back('{l0: a, l1: b, l2: c, l3: d, cnt: n});
  endtask

  // Present one word and return #1 after the edge that accepts it.
  task automatic send(input logic [15:0] d, input logic last);
    logic acc;
    int   guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_lanes", {out00, out01} | {out10, out11}, 32'd0);
    chk("reset_count", {29'd0, out_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Full group, one-cycle latency
    out_ready = 1'b1;
    push(16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd4);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0004, 1'b0);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_out11", {16'd0, out11}, 32'h0004);
    idle(2);

    // Partial groups via in_last
    push(16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 3'd2);
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b1);
    idle(2);
    push(16'h1234, 16'h0000, 16'h0000, 16'h0000, 3'd1);
    send(16'h1234, 1'b1);
    chk("single_count", {29'd0, out_count}, 32'd1);
    idle(2);

    // in_last on the 4th word behaves like a plain full group
    push(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 3'd4);
    send(16'h00A1, 1'b0);
    send(16'h00A2, 1'b0);
    send(16'h00A3, 1'b0);
    send(16'h00A4, 1'b1);
    idle(2);

    // Backpressure: second group parks in FULL until out_ready returns
    out_ready = 1'b0;
    push(16'h0005, 16'h0006, 16'h0007, 16'h0008, 3'd4);
    push(16'h0009, 16'h000A, 16'h000B, 16'h000C, 3'd4);
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    send(16'h0007, 1'b0);
    send(16'h0008, 1'b0);
    send(16'h0009, 1'b0);
    send(16'h000A, 1'b0);
    send(16'h000B, 1'b0);
    send(16'h000C, 1'b0);
    chk("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("hold_out00", {16'd0, out00}, 32'h0005);
    idle(3);
    chk("hold_out11_stable", {16'd0, out11}, 32'h0008);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out00", {16'd0, out00}, 32'h0009);
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    idle(2);

    // Streaming: a group every 4th cycle, no bubbles
    for (int g = 0; g < 4; g++)
      push(16'(4*g), 16'(4*g+1), 16'(4*g+2), 16'(4*g+3), 3'd4);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      in_last  = 1'b0;
      @(negedge clk);
      chk($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, {31'd0, (i % 4) == 3});
    end
    idle(3);

    // Reset mid-group discards partial words
    send(16'h0020, 1'b0);
    send(16'h0021, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    push(16'h0010, 16'h0011, 16'h0012, 16'h0013, 3'd4);
    send(16'h0010, 1'b0);
    send(16'h0011, 1'b0);
    send(16'h0012, 1'b0);
    send(16'h0013, 1'b0);
    idle(4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_scatter_4way_16bit.md
OPERAND_SCATTER_4WAY_16BIT -- requirements
Module: operand_scatter_4way_16bit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of each operand word.
REQ-002 SHALL have parameter LANES, fixed at 4, meaning output lane count (out00, out01, out10, out11).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  DATA_W  serial operand word.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_last  input  1  marks final word of a partial group; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have ports out00, out01, out10, out11  output  DATA_W each  parallel operand lanes.
REQ-010 SHALL have port out_count  output  3  number of real words in the group, 1..4.
REQ-011 SHALL have port out_valid  output  1  parallel group valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the group.

Function
REQ-013 A word SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-014 Accepted words of a group SHALL map in order: 1st to out00, 2nd to out01, 3rd to out10, 4th to out11.
REQ-015 A group SHALL close on the 4th accepted word, or on any accepted word with in_last=1; in_last on the 4th word is equivalent to no in_last.
REQ-016 Lanes not filled in a closed group SHALL be 0, and out_count SHALL equal the words received.
REQ-017 Collector states SHALL be COLLECT (count 0..3) and FULL (closed group waiting for the output register).
REQ-018 Output slot SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-019 On the closing edge with the slot free, the group SHALL load directly into the output registers, set out_valid=1 and return the count to 0. Latency: out_valid high in the cycle after the closing word is accepted.
REQ-020 On the closing edge with the slot not free, the collector SHALL enter FULL. The group SHALL transfer on the first edge where the slot is free, and the collector SHALL return to COLLECT with count 0.
REQ-021 in_ready SHALL be 1 in COLLECT and 0 in FULL, independent of in_valid.
REQ-022 out_valid SHALL stay 1, with out00..out11 and out_count stable, until an edge with out_ready=1. It SHALL then clear unless a new group loads on the same edge.
REQ-023 With continuous in_valid and out_ready, throughput SHALL be one word per cycle with no bubbles.
REQ-024 Data SHALL pass unmodified; no arithmetic or width change.

Reset
REQ-025 While reset=1: out00..out11=0, out_count=0, out_valid=0, in_ready=0, collector state COLLECT with count 0.
REQ-026 Reset asserted mid-group or mid-hold SHALL discard all partial and pending words.
REQ-027 in_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-028 A shared package operand_scatter_pkg SHALL hold DATA_W, LANES and the collector state enumeration.
REQ-029 The block SHALL be one flat module; the collector and the output register stay in it, with no sub-module.

Verification
REQ-030 Accept 0x0001, 0x0002, 0x0003, 0x0004 back-to-back with out_ready=1 -> next cycle: out00..out11 = 1,2,3,4, out_count=4, out_valid=1.
REQ-031 Accept 0xAAAA, then 0xBBBB with in_last=1 -> out00=0xAAAA, out01=0xBBBB, out10=out11=0, out_count=2.
REQ-032 Hold out_ready=0 while a group is valid and send 4 more words -> in_ready=0 after the 4th word, first group stable; raise out_ready -> second group appears the next cycle, then in_ready=1.
REQ-033 Stream 16 words 0x0000..0x000F with in_valid=out_ready=1 -> 4 groups on consecutive-4-cycle boundaries, in_ready never low.
REQ-034 Assert reset after 2 words of a group, then send 0x0010..0x0013 -> out00..out11 = 0x10..0x13 with out_count=4; no earlier words appear.
REQ-035 Send a single word 0x1234 with in_last=1 -> out00=0x1234, other lanes 0, out_count=1.
